ad_fifo_ctrl: RTL and testbench
===============================

Name: ad_fifo_ctrl

Overview:
- Drift controller for the USB2 add/drop elasticity FIFO (ad_fifo).
- Integrates Early/Late pulses from the receive phase detector and decides when to slip a bit.
- Issues single-cycle Add/Drop commands aligned to the CRD strobe, enforcing holdoff and net-offset limits.
- Handles FIFO Overflow/Underflow by entering a fault/recovery sequence; sits between the phase detector and ad_fifo.

Parameters:
- ACC_W, 6, width of signed drift accumulator.
- THRESH, 4, |accumulator| value that triggers a command (1 .. 2^(ACC_W-1)-1).
- HOLDOFF, 8, Clock cycles after a command during which no new command is issued.
- MAX_OFF, 7, max |net offset| (Adds minus Drops) before commands in that direction are suppressed.
- RECOVER, 16, Clock cycles spent in FAULT before tracking resumes.

Ports:
- Clock  in  1  single system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to Clock).
- CRD  in  1  recovered-data strobe; Add/Drop are only asserted in CRD=1 cycles.
- Early  in  1  phase detector: sample early, one-cycle pulse.
- Late  in  1  phase detector: sample late, one-cycle pulse.
- Overflow  in  1  from ad_fifo.
- Underflow  in  1  from ad_fifo.
- Add  out  1  to ad_fifo; one-cycle command.
- Drop  out  1  to ad_fifo; one-cycle command.
- Fault  out  1  sticky; set on Overflow/Underflow, cleared only by Reset.
- Limit  out  1  high while |net offset| == MAX_OFF.
- Offset  out  $clog2(MAX_OFF+1)+1  signed net offset (Adds minus Drops).

Behaviour:
- Reset (Reset=0): state=TRACK, accumulator=0, Offset=0, holdoff counter=0. Outputs Add=0, Drop=0, Fault=0, Limit=0.
- Accumulator, every cycle outside FAULT:
  - Late & !Early -> +1; Early & !Late -> -1; both high or both low -> unchanged.
  - Saturates at ±(2^(ACC_W-1)-1); never wraps.
- FSM states: TRACK, ISSUE_ADD, ISSUE_DROP, HOLD, FAULT.
- TRACK:
  - acc >= THRESH and Offset < MAX_OFF -> ISSUE_ADD.
  - acc <= -THRESH and Offset > -MAX_OFF -> ISSUE_DROP.
  - Threshold reached but Offset is at the limit in that direction -> remain in TRACK and clamp acc to ±THRESH.
  - Limit = (|Offset| == MAX_OFF).
- ISSUE_ADD / ISSUE_DROP:
  - Add = (state==ISSUE_ADD) & CRD; Drop = (state==ISSUE_DROP) & CRD (combinational, coincident with CRD).
  - In the CRD=1 cycle: Offset ±1, acc cleared to 0 (Early/Late that cycle ignored), next state HOLD with counter=HOLDOFF-1.
  - While CRD=0: wait; acc keeps integrating.
- HOLD: decrement counter; at 0 -> TRACK. Acc integrates; no commands are issued.
- Add and Drop are never high in the same cycle; at most one command per ISSUE visit.
- Overflow or Underflow in any state, including mid-ISSUE:
  - Next state FAULT; Fault<=1; acc<=0; Offset<=0; counter=RECOVER-1.
  - An ISSUE cycle coinciding with the fault still emits its Add/Drop if CRD=1, but Offset is cleared rather than updated.
- FAULT: Add=Drop=0; Early/Late ignored; count down; at 0 -> TRACK. A fresh Overflow/Underflow during FAULT reloads the counter.
- Reset assertion mid-operation: immediate return to reset values; a pending command is discarded.

Decomposition:
- Shared package usb2_pkg:
  - state enum for ad_fifo_ctrl_state_t.
  - default THRESH/HOLDOFF/RECOVER constants shared with the ad_fifo bench (FIFO_SIZE lives here too).
- One natural sub-module: drift_accum (saturating signed up/down accumulator with clear and clamp inputs). The FSM, counter and offset logic stay in ad_fifo_ctrl.

Test Plan:
- Reset, then 4 Late pulses with CRD toggling 0,1 -> exactly one Add pulse in the first CRD=1 cycle after acc reaches 4; Offset=1; no command for the next 8 cycles.
- 4 Early pulses during HOLD, then idle -> Drop issued in the first CRD=1 cycle after HOLD expires; Offset returns to 0.
- Continuous Late for 200 cycles -> Adds spaced ≥ HOLDOFF+1 cycles; Offset stops at 7; Limit=1; no further Add; acc stays clamped at 4.
- Early and Late asserted together for 50 cycles -> acc stays 0; no Add/Drop.
- Overflow pulse while in ISSUE_ADD with CRD=0 -> no Add; Fault=1; Offset=0; Early/Late ignored for 16 cycles; tracking resumes; Fault stays 1.
- Assert Reset mid-HOLD with Offset=3 -> all outputs and Offset are 0 immediately, before the next Clock edge.

Source files
------------

// File: rtl/usb2_pkg.sv
// Shared USB2 receive-path definitions: default elasticity/drift constants and
// the add/drop controller state encoding, used by ad_fifo and its controller.
package usb2_pkg;

    localparam int FIFO_SIZE    = 16;
    localparam int ACC_W_DEF    = 6;
    localparam int THRESH_DEF   = 4;
    localparam int HOLDOFF_DEF  = 8;
    localparam int RECOVER_DEF  = 16;
    // The net slip may not exceed what half the elasticity buffer can absorb.
    localparam int MAX_OFF_DEF  = FIFO_SIZE / 2 - 1;

    typedef enum logic [2:0] {
        ST_TRACK      = 3'd0,
        ST_ISSUE_ADD  = 3'd1,
        ST_ISSUE_DROP = 3'd2,
        ST_HOLD       = 3'd3,
        ST_FAULT      = 3'd4
    } ad_fifo_ctrl_state_t;

    function automatic int off_width(input int max_off);
        return $clog2(max_off + 1) + 1;
    endfunction

    function automatic int cnt_width(input int holdoff, input int recover);
        int m;
        m = (holdoff > recover) ? holdoff : recover;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ad_fifo_ctrl_if.sv
// Signals between the drift controller, the receive phase detector and ad_fifo.
// master = the controller, slave = the phase detector / FIFO side.
interface ad_fifo_ctrl_if #(
    parameter int OFF_W = usb2_pkg::off_width(usb2_pkg::MAX_OFF_DEF)
) ();

    logic                    crd;
    logic                    early;
    logic                    late;
    logic                    overflow;
    logic                    underflow;
    logic                    add;
    logic                    drop;
    logic                    fault;
    logic                    limit;
    logic signed [OFF_W-1:0] offset;

    modport master (
        input  crd, early, late, overflow, underflow,
        output add, drop, fault, limit, offset
    );

    modport slave (
        output crd, early, late, overflow, underflow,
        input  add, drop, fault, limit, offset
    );

endinterface

// File: rtl/ad_fifo_ctrl_drift_accum.sv
// Saturating signed up/down drift accumulator with synchronous clear and an
// optional clamp to +/-THRESH used while the net offset sits at its limit.
module drift_accum #(
    parameter int ACC_W  = 6,
    parameter int THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    clamp_hi,
    input  logic                    clamp_lo,
    input  logic                    up,
    input  logic                    down,
    output logic signed [ACC_W-1:0] acc
);

    localparam int W = ACC_W + 1;
    localparam logic signed [W-1:0] SAT_POS = W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [W-1:0] SAT_NEG = W'(-(2 ** (ACC_W - 1) - 1));
    localparam logic signed [W-1:0] CLP_POS = W'(THRESH);
    localparam logic signed [W-1:0] CLP_NEG = W'(-THRESH);
    localparam logic signed [W-1:0] ONE     = W'(1);

    logic signed [W-1:0]     sum;
    logic signed [ACC_W-1:0] acc_d;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sum   = {acc[ACC_W-1], acc};
        acc_d = acc;
        if (up && !down) begin
            sum = sum + ONE;
        end else if (down && !up) begin
            sum = sum - ONE;
        end
        // One extra bit of headroom lets saturation be a plain compare.
        if (sum > SAT_POS) begin
            sum = SAT_POS;
        end else if (sum < SAT_NEG) begin
            sum = SAT_NEG;
        end
        if (clamp_hi && sum > CLP_POS) begin
            sum = CLP_POS;
        end
        if (clamp_lo && sum < CLP_NEG) begin
            sum = CLP_NEG;
        end
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/ad_fifo_ctrl.sv
// USB2 add/drop elasticity drift controller: turns integrated Early/Late phase
// pulses into CRD-aligned single-cycle Add/Drop slips, with holdoff, offset limit and fault recovery.
module ad_fifo_ctrl
    import usb2_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int THRESH  = THRESH_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int MAX_OFF = MAX_OFF_DEF,
    parameter int RECOVER = RECOVER_DEF
) (
    input logic            clk,
    input logic            rst_n,
    ad_fifo_ctrl_if.master bus
);

    localparam int OFF_W = off_width(MAX_OFF);
    localparam int CNT_W = cnt_width(HOLDOFF, RECOVER);

    localparam logic signed [OFF_W-1:0] OFF_POS = OFF_W'(MAX_OFF);
    localparam logic signed [OFF_W-1:0] OFF_NEG = OFF_W'(-MAX_OFF);
    localparam logic signed [OFF_W-1:0] OFF_ONE = OFF_W'(1);
    localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG = ACC_W'(-THRESH);
    localparam logic [CNT_W-1:0]        HOLD_LD = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0]        RECV_LD = CNT_W'(RECOVER - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

    ad_fifo_ctrl_state_t     state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OFF_W-1:0] off_q, off_d;
    logic                    fault_q, fault_d;

    logic                    acc_en;
    logic                    acc_clr;
    logic                    clamp_hi;
    logic                    clamp_lo;
    logic signed [ACC_W-1:0] acc;
    logic                    fifo_err;

    assign fifo_err = bus.overflow | bus.underflow;

    drift_accum #(
        .ACC_W  (ACC_W),
        .THRESH (THRESH)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (acc_en),
        .clear    (acc_clr),
        .clamp_hi (clamp_hi),
        .clamp_lo (clamp_lo),
        .up       (bus.late),
        .down     (bus.early),
        .acc      (acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        fault_d  = fault_q;
        acc_en   = 1'b1;
        acc_clr  = 1'b0;
        clamp_hi = 1'b0;
        clamp_lo = 1'b0;

        unique case (state_q)
            ST_TRACK: begin
                // At the offset limit the accumulator is pinned so it cannot wind up.
                if (acc >= THR_POS) begin
                    if (off_q < OFF_POS) state_d = ST_ISSUE_ADD;
                    else                 clamp_hi = 1'b1;
                end else if (acc <= THR_NEG) begin
                    if (off_q > OFF_NEG) state_d = ST_ISSUE_DROP;
                    else                 clamp_lo = 1'b1;
                end
            end
            ST_ISSUE_ADD, ST_ISSUE_DROP: begin
                if (bus.crd) begin
                    off_d   = (state_q == ST_ISSUE_ADD) ? off_q + OFF_ONE : off_q - OFF_ONE;
                    acc_clr = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_TRACK;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_FAULT: begin
                acc_en = 1'b0;
                if (cnt_q == '0) state_d = ST_TRACK;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: begin
                state_d = ST_TRACK;
            end
        endcase

        // FIFO errors override everything, including a command issued this cycle.
        if (fifo_err) begin
            state_d = ST_FAULT;
            cnt_d   = RECV_LD;
            off_d   = '0;
            fault_d = 1'b1;
            acc_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_TRACK;
            cnt_q   <= '0;
            off_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            fault_q <= fault_d;
        end
    end

    assign bus.add    = (state_q == ST_ISSUE_ADD)  & bus.crd;
    assign bus.drop   = (state_q == ST_ISSUE_DROP) & bus.crd;
    assign bus.fault  = fault_q;
    assign bus.limit  = (off_q == OFF_POS) | (off_q == OFF_NEG);
    assign bus.offset = off_q;

endmodule

// File: tb/tb_ad_fifo_ctrl.sv
// Self-checking bench for ad_fifo_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_ad_fifo_ctrl;

    localparam int ACC_W   = 6;
    localparam int THRESH  = 4;
    localparam int HOLDOFF = 8;
    localparam int MAX_OFF = 7;
    localparam int RECOVER = 16;
    localparam int OFF_W   = $clog2(MAX_OFF + 1) + 1;
    localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ad_fifo_ctrl_if #(.OFF_W(OFF_W)) bus ();

    ad_fifo_ctrl #(
        .ACC_W   (ACC_W),
        .THRESH  (THRESH),
        .HOLDOFF (HOLDOFF),
        .MAX_OFF (MAX_OFF),
        .RECOVER (RECOVER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // pend: +1 an Add is owed, -1 a Drop is owed; hold/recov: blackout cycles left.
    int m_acc, m_off, m_pend, m_hold, m_recov, m_fault, m_next, m_d;

    function automatic int sat(input int v);
        if (v > ACC_MAX)  return ACC_MAX;
        if (v < -ACC_MAX) return -ACC_MAX;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc = 0; m_off = 0; m_pend = 0; m_hold = 0; m_recov = 0; m_fault = 0;
        end
        check("add",    bus.add,    (m_pend == 1 && bus.crd) ? 1 : 0);
        check("drop",   bus.drop,   (m_pend == -1 && bus.crd) ? 1 : 0);
        check("fault",  bus.fault,  m_fault);
        check("limit",  bus.limit,  (m_off == MAX_OFF || m_off == -MAX_OFF) ? 1 : 0);
        check("offset", bus.offset, m_off);
        if (rst_n) begin
            m_d = (bus.late && !bus.early) ? 1 : ((bus.early && !bus.late) ? -1 : 0);
            if (bus.overflow || bus.underflow) begin
                m_acc = 0; m_off = 0; m_pend = 0; m_hold = 0;
                m_recov = RECOVER; m_fault = 1;
            end else if (m_recov > 0) begin
                m_recov--;
            end else if (m_pend != 0 && bus.crd) begin
                m_off  += m_pend;
                m_pend  = 0;
                m_acc   = 0;
                m_hold  = HOLDOFF;
            end else if (m_pend != 0 || m_hold > 0) begin
                if (m_hold > 0) m_hold--;
                m_acc = sat(m_acc + m_d);
            end else begin
                m_next = sat(m_acc + m_d);
                if (m_acc >= THRESH) begin
                    if (m_off < MAX_OFF)     m_pend = 1;
                    else if (m_next > THRESH) m_next = THRESH;
                end else if (m_acc <= -THRESH) begin
                    if (m_off > -MAX_OFF)     m_pend = -1;
                    else if (m_next < -THRESH) m_next = -THRESH;
                end
                m_acc = m_next;
            end
        end
    end

    // ---------------- stimulus ----------------
    int add_cnt = 0;
    int drop_cnt = 0;
    int cyc_idx = 0;
    int last_add = -1000;
    int min_gap = 1000;

    task automatic cyc(input logic c, input logic e, input logic l, input logic ov, input logic un);
        @(posedge clk);
        #1;
        bus.crd = c; bus.early = e; bus.late = l; bus.overflow = ov; bus.underflow = un;
        @(negedge clk);
        cyc_idx++;
        if (bus.add) begin
            if (cyc_idx - last_add < min_gap) min_gap = cyc_idx - last_add;
            last_add = cyc_idx;
            add_cnt++;
        end
        if (bus.drop) drop_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int a0, d0, bias, r;
        logic e, l;
        bus.crd = 0; bus.early = 0; bus.late = 0; bus.overflow = 0; bus.underflow = 0;
        repeat (2) @(negedge clk);
        check("reset_add", bus.add, 0);
        check("reset_fault", bus.fault, 0);
        check("reset_offset", bus.offset, 0);
        #2 rst_n = 1'b1;

        // 4 Late pulses with CRD toggling -> one Add, then 4 Early during HOLD -> one Drop
        for (int i = 0; i < 4; i++) cyc(i[0], 0, 1, 0, 0);
        for (int i = 0; i < 20 && add_cnt == 0; i++) cyc(i[0], 0, 0, 0, 0);
        check("first_add_count", add_cnt, 1);
        for (int i = 0; i < 4; i++) cyc(i[0], 1, 0, 0, 0);
        check("offset_after_add", bus.offset, 1);
        check("no_drop_in_hold", drop_cnt, 0);
        for (int i = 0; i < 20; i++) cyc(i[0], 0, 0, 0, 0);
        check("single_add", add_cnt, 1);
        check("drop_count", drop_cnt, 1);
        check("offset_back_to_0", bus.offset, 0);

        // continuous Late: offset saturates at MAX_OFF
        last_add = -1000; min_gap = 1000; a0 = add_cnt;
        for (int i = 0; i < 200; i++) cyc(1'($urandom_range(0, 1)), 0, 1, 0, 0);
        check("adds_to_limit", add_cnt - a0, 7);
        check("offset_at_limit", bus.offset, 7);
        check("limit_flag", bus.limit, 1);
        check("add_spacing_ok", (min_gap >= HOLDOFF + 1) ? 1 : 0, 1);

        // acc pinned at +THRESH: 7 Early only reach -3, the 8th reaches -4
        d0 = drop_cnt;
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0);
        check("clamp_no_drop", drop_cnt - d0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0);
        check("clamp_drop", drop_cnt - d0, 1);
        check("offset_6", bus.offset, 6);
        check("limit_clear", bus.limit, 0);

        // Early and Late together: no drift
        a0 = add_cnt; d0 = drop_cnt;
        for (int i = 0; i < 50; i++) cyc(1'($urandom_range(0, 1)), 1, 1, 0, 0);
        check("both_no_add", add_cnt - a0, 0);
        check("both_no_drop", drop_cnt - d0, 0);

        // Overflow while waiting in ISSUE_ADD with CRD low
        a0 = add_cnt;
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < RECOVER; i++) cyc(1, 0, 1, 0, 0);
        check("fault_no_add", add_cnt - a0, 0);
        check("fault_set", bus.fault, 1);
        check("fault_offset", bus.offset, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 0);
        check("resume_add", add_cnt - a0, 1);
        check("fault_sticky", bus.fault, 1);
        check("resume_offset", bus.offset, 1);

        // reach Offset=3 in HOLD, then asynchronous reset mid-cycle
        a0 = add_cnt;
        for (int i = 0; i < 60 && add_cnt - a0 < 2; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("offset_3", bus.offset, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_add", bus.add, 0);
        check("async_rst_drop", bus.drop, 0);
        check("async_rst_fault", bus.fault, 0);
        check("async_rst_limit", bus.limit, 0);
        check("async_rst_offset", bus.offset, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // randomized traffic in biased segments
        for (int s = 0; s < 20; s++) begin
            bias = $urandom_range(0, 2);
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 99);
                case (bias)
                    0:       begin l = (r < 50); e = (r >= 85); end
                    1:       begin e = (r < 50); l = (r >= 85); end
                    default: begin e = (r < 30); l = (r >= 70); end
                endcase
                cyc(1'($urandom_range(0, 1)), e, l,
                    ($urandom_range(0, 399) == 0), ($urandom_range(0, 399) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
